// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
//
// Register-hazard tracker for the decode (ID) stage. Each architectural
// register r (1..NREG-1) owns a saturating in-flight-write counter. The
// counter goes up when an instruction that writes r issues from ID to EX and
// goes down when WB commits the write to r. Register 0 is never tracked and
// always reads as "nothing in flight".
//
// The counters drive per-source busy flags, a destination-saturation flag
// and the ds_ready_go term used by the ID allowin logic.
//
// Build option:
//   SCOREBOARD_BYPASS_EN  when defined, a pending source is resolved from the
//                         youngest ES/MS/WS producer instead of stalling
//                         (an ES load still stalls). When undefined, every
//                         es_/ms_/ws_ input is ignored and a pending source is
//                         simply busy. The ports exist in both builds.
//
// Transfer qualifiers: issue_valid and retire_valid are single-cycle event
// strobes, not handshakes. issue_valid must only be high in a cycle where the
// ID->EX transfer really happens (ds_to_es_valid && es_allowin); retire_valid
// must only be high in a cycle where WB writes the register file. Each high
// cycle counts as exactly one event; there is no back-pressure on either.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   issue_valid/we/waddr          ID->EX issue event and its destination
//   rs_addr, rt_addr              source registers of the instruction in ID
//   dst_addr, dst_we              destination of the instruction in ID
//   retire_valid/waddr            WB register-file commit event
//   flush                         synchronous clear of all counters
//   {es,ms,ws}_valid/rf_we/waddr/wdata, es_is_load
//                                 producer stages (bypass build only)
//   rs_rf_data, rt_rf_data        register file read data
//   rs_busy, rt_busy              source operand not usable this cycle
//   dst_full                      destination counter is saturated
//   ds_ready_go                   !rs_busy && !rt_busy && !dst_full
//   rs_fwd_data, rt_fwd_data      operand data handed to ID
//   sb_err                        sticky over/underflow error
// ---------------------------------------------------------------------------
module id_scoreboard #(
  parameter int AW    = 5,
  parameter int CNT_W = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  // issue side
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [AW-1:0] issue_waddr,
  // instruction currently in ID
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic          dst_we,
  // commit side
  input  logic          retire_valid,
  input  logic [AW-1:0] retire_waddr,
  input  logic          flush,
  // producer stages
  input  logic          es_valid,
  input  logic          ms_valid,
  input  logic          ws_valid,
  input  logic          es_rf_we,
  input  logic          ms_rf_we,
  input  logic          ws_rf_we,
  input  logic [AW-1:0] es_waddr,
  input  logic [AW-1:0] ms_waddr,
  input  logic [AW-1:0] ws_waddr,
  input  logic          es_is_load,
  input  logic [DW-1:0] es_wdata,
  input  logic [DW-1:0] ms_wdata,
  input  logic [DW-1:0] ws_wdata,
  // register file read data
  input  logic [DW-1:0] rs_rf_data,
  input  logic [DW-1:0] rt_rf_data,
  // results
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          dst_full,
  output logic          ds_ready_go,
  output logic [DW-1:0] rs_fwd_data,
  output logic [DW-1:0] rt_fwd_data,
  output logic          sb_err
);

  localparam int              NREG    = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Operand resolution result for one source.
  typedef struct packed {
    logic          busy;
    logic [DW-1:0] data;
  } src_res_t;

  // -------------------------------------------------------------------------
  // Counter storage. Entry 0 is held at zero by both reset and next-state
  // logic so that a register-0 lookup needs no special case downstream.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q;
  logic             err_d;
  logic             overflow;
  logic             underflow;

  always_comb begin
    cnt_d[0]  = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        // Flush wins over any issue/retire landing in the same cycle; the
        // overridden events are discarded and cannot raise an error.
        cnt_d[r] = '0;
      end else begin
        if ((issue_valid && issue_we && (issue_waddr == AW'(r))) &&
            !(retire_valid && (retire_waddr == AW'(r)))) begin
          if (cnt_q[r] == CNT_MAX) begin
            overflow = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] + 1'b1;
          end
        end
        if ((retire_valid && (retire_waddr == AW'(r))) &&
            !(issue_valid && issue_we && (issue_waddr == AW'(r)))) begin
          if (cnt_q[r] == '0) begin
            underflow = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] - 1'b1;
          end
        end
      end
    end
    // Sticky: once set only reset clears it.
    err_d = err_q | overflow | underflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Lookups. cnt_q[0] is constant zero, so address-0 sources are never
  // pending.
  // -------------------------------------------------------------------------
  logic rs_pending;
  logic rt_pending;

  assign rs_pending = (cnt_q[rs_addr] != '0);
  assign rt_pending = (cnt_q[rt_addr] != '0);

  assign dst_full = dst_we && (cnt_q[dst_addr] == CNT_MAX) && (dst_addr != '0);

  src_res_t rs_res;
  src_res_t rt_res;

`ifdef SCOREBOARD_BYPASS_EN
  // Pick the youngest matching producer (ES > MS > WS). A pending source with
  // no matching producer in flight is still waiting for an older write that
  // is past our view, so it stays busy and keeps the RF value.
  function automatic src_res_t resolve(input logic [AW-1:0] addr,
                                       input logic          pending,
                                       input logic [DW-1:0] rf_data);
    src_res_t res;
    res.busy = 1'b0;
    res.data = rf_data;
    if (pending) begin
      if (es_valid && es_rf_we && (es_waddr == addr)) begin
        // Load data is not available until MS; this is the load-use stall.
        res.busy = es_is_load;
        res.data = es_wdata;
      end else if (ms_valid && ms_rf_we && (ms_waddr == addr)) begin
        res.data = ms_wdata;
      end else if (ws_valid && ws_rf_we && (ws_waddr == addr)) begin
        res.data = ws_wdata;
      end else begin
        res.busy = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    rs_res = resolve(rs_addr, rs_pending, rs_rf_data);
    rt_res = resolve(rt_addr, rt_pending, rt_rf_data);
  end
`else
  always_comb begin
    rs_res.busy = rs_pending;
    rs_res.data = rs_rf_data;
    rt_res.busy = rt_pending;
    rt_res.data = rt_rf_data;
  end

  // Producer-stage inputs have no function in this build.
  logic unused_stage_inputs;
  assign unused_stage_inputs = ^{es_valid, ms_valid, ws_valid,
                                 es_rf_we, ms_rf_we, ws_rf_we,
                                 es_waddr, ms_waddr, ws_waddr,
                                 es_is_load, es_wdata, ms_wdata, ws_wdata};
`endif

  assign rs_busy     = rs_res.busy;
  assign rt_busy     = rt_res.busy;
  assign rs_fwd_data = rs_res.data;
  assign rt_fwd_data = rt_res.data;
  assign ds_ready_go = !rs_busy && !rt_busy && !dst_full;
  assign sb_err      = err_q;

endmodule
